// File: rtl/wb_dest_pipe.sv
// wb_dest_pipe: EX/MEM and MEM/WB destination pipeline registers feeding the
// forwarding unit, plus load-use hazard detection against IF/ID and a
// saturating count of load-use stall cycles.
module wb_dest_pipe #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              Hold,
    input  logic              Flush_EX,
    input  logic [4:0]        ID_EX_Rd,
    input  logic              ID_EX_RegWrite,
    input  logic              ID_EX_MemRead,
    input  logic [DATA_W-1:0] EX_ALU_Out,
    input  logic [DATA_W-1:0] MEM_Read_Data,
    input  logic [4:0]        IF_ID_Rs,
    input  logic [4:0]        IF_ID_Rt,
    output logic [4:0]        EX_MEM_Rd,
    output logic              EX_MEM_RegWrite,
    output logic              EX_MEM_MemRead,
    output logic [DATA_W-1:0] EX_MEM_ALU_Out,
    output logic [4:0]        MEM_WB_Rd,
    output logic              MEM_WB_RegWrite,
    output logic [DATA_W-1:0] MEM_WB_Data,
    output logic              Load_Use_Stall,
    output logic [CNT_W-1:0]  Stall_Count
);

    logic ex_writes_reg;

    // A write to $zero is dropped here so neither slice ever advertises it.
    always_comb begin
        ex_writes_reg  = ID_EX_RegWrite && (ID_EX_Rd != 5'd0);
        Load_Use_Stall = ID_EX_MemRead && ex_writes_reg &&
                         ((ID_EX_Rd == IF_ID_Rs) || (ID_EX_Rd == IF_ID_Rt));
    end

    // EX/MEM slice: reset > hold > flush bubble > capture from EX.
    always_ff @(posedge clk) begin
        if (reset) begin
            EX_MEM_Rd       <= '0;
            EX_MEM_RegWrite <= 1'b0;
            EX_MEM_MemRead  <= 1'b0;
            EX_MEM_ALU_Out  <= '0;
        end else if (!Hold) begin
            if (Flush_EX) begin
                EX_MEM_Rd       <= '0;
                EX_MEM_RegWrite <= 1'b0;
                EX_MEM_MemRead  <= 1'b0;
                EX_MEM_ALU_Out  <= '0;
            end else begin
                EX_MEM_Rd       <= ID_EX_Rd;
                EX_MEM_RegWrite <= ex_writes_reg;
                EX_MEM_MemRead  <= ID_EX_MemRead;
                EX_MEM_ALU_Out  <= EX_ALU_Out;
            end
        end
    end

    // MEM/WB slice: advances from the old EX/MEM contents even on a flush edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            MEM_WB_Rd       <= '0;
            MEM_WB_RegWrite <= 1'b0;
            MEM_WB_Data     <= '0;
        end else if (!Hold) begin
            MEM_WB_Rd       <= EX_MEM_Rd;
            MEM_WB_RegWrite <= EX_MEM_RegWrite;
            MEM_WB_Data     <= EX_MEM_MemRead ? MEM_Read_Data : EX_MEM_ALU_Out;
        end
    end

    // Saturating load-use stall counter; keeps counting while the pipe is held.
    always_ff @(posedge clk) begin
        if (reset) begin
            Stall_Count <= '0;
        end else if (Load_Use_Stall && (Stall_Count != '1)) begin
            Stall_Count <= Stall_Count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_wb_dest_pipe.sv
// Directed bench for wb_dest_pipe: expected values are queued as each step is
// driven and drained against the DUT after the following clock edge.
module tb_wb_dest_pipe;

    localparam int DATA_W = 32;
    localparam int CNT_W  = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic              Hold;
    logic              Flush_EX;
    logic [4:0]        ID_EX_Rd;
    logic              ID_EX_RegWrite;
    logic              ID_EX_MemRead;
    logic [DATA_W-1:0] EX_ALU_Out;
    logic [DATA_W-1:0] MEM_Read_Data;
    logic [4:0]        IF_ID_Rs;
    logic [4:0]        IF_ID_Rt;
    logic [4:0]        EX_MEM_Rd;
    logic              EX_MEM_RegWrite;
    logic              EX_MEM_MemRead;
    logic [DATA_W-1:0] EX_MEM_ALU_Out;
    logic [4:0]        MEM_WB_Rd;
    logic              MEM_WB_RegWrite;
    logic [DATA_W-1:0] MEM_WB_Data;
    logic              Load_Use_Stall;
    logic [CNT_W-1:0]  Stall_Count;

    wb_dest_pipe #(
        .DATA_W(DATA_W),
        .CNT_W (CNT_W)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .Hold           (Hold),
        .Flush_EX       (Flush_EX),
        .ID_EX_Rd       (ID_EX_Rd),
        .ID_EX_RegWrite (ID_EX_RegWrite),
        .ID_EX_MemRead  (ID_EX_MemRead),
        .EX_ALU_Out     (EX_ALU_Out),
        .MEM_Read_Data  (MEM_Read_Data),
        .IF_ID_Rs       (IF_ID_Rs),
        .IF_ID_Rt       (IF_ID_Rt),
        .EX_MEM_Rd      (EX_MEM_Rd),
        .EX_MEM_RegWrite(EX_MEM_RegWrite),
        .EX_MEM_MemRead (EX_MEM_MemRead),
        .EX_MEM_ALU_Out (EX_MEM_ALU_Out),
        .MEM_WB_Rd      (MEM_WB_Rd),
        .MEM_WB_RegWrite(MEM_WB_RegWrite),
        .MEM_WB_Data    (MEM_WB_Data),
        .Load_Use_Stall (Load_Use_Stall),
        .Stall_Count    (Stall_Count)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        int          sel;
        logic [31:0] exp;
    } exp_t;

    exp_t sbq[$];
    int   n_assert = 0;
    int   n_fail   = 0;

    function automatic logic [31:0] obs(int sel);
        case (sel)
            0: return 32'(EX_MEM_Rd);
            1: return 32'(EX_MEM_RegWrite);
            2: return 32'(EX_MEM_MemRead);
            3: return EX_MEM_ALU_Out;
            4: return 32'(MEM_WB_Rd);
            5: return 32'(MEM_WB_RegWrite);
            6: return MEM_WB_Data;
            7: return 32'(Load_Use_Stall);
            8: return 32'(Stall_Count);
            default: return 'x;
        endcase
    endfunction

    task automatic push(input string tag, input int sel, input logic [31:0] e);
        exp_t t;
        t.tag = tag;
        t.sel = sel;
        t.exp = e;
        sbq.push_back(t);
    endtask

    task automatic drain();
        exp_t        t;
        logic [31:0] o;
        while (sbq.size() > 0) begin
            t = sbq.pop_front();
            o = obs(t.sel);
            n_assert++;
            assert (o === t.exp) else begin
                n_fail++;
                $error("FAIL %s: observed %0h expected %0h", t.tag, o, t.exp);
            end
        end
    endtask

    task automatic exp_exm(input string tag, input logic [4:0] rd, input logic rw,
                           input logic mr, input logic [31:0] alu);
        push({tag, ".ex_mem_rd"}, 0, 32'(rd));
        push({tag, ".ex_mem_regwrite"}, 1, 32'(rw));
        push({tag, ".ex_mem_memread"}, 2, 32'(mr));
        push({tag, ".ex_mem_alu"}, 3, alu);
    endtask

    task automatic exp_mwb(input string tag, input logic [4:0] rd, input logic rw,
                           input logic [31:0] data);
        push({tag, ".mem_wb_rd"}, 4, 32'(rd));
        push({tag, ".mem_wb_regwrite"}, 5, 32'(rw));
        push({tag, ".mem_wb_data"}, 6, data);
    endtask

    task automatic drive_ex(input logic [4:0] rd, input logic rw, input logic mr,
                            input logic [31:0] alu, input logic [4:0] rs,
                            input logic [4:0] rt);
        ID_EX_Rd       = rd;
        ID_EX_RegWrite = rw;
        ID_EX_MemRead  = mr;
        EX_ALU_Out     = alu;
        IF_ID_Rs       = rs;
        IF_ID_Rt       = rt;
    endtask

    // Check the combinational stall output after inputs settle.
    task automatic check_stall(input string tag, input logic e);
        #1;
        push(tag, 7, 32'(e));
        drain();
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        drain();
    endtask

    initial begin
        // 1. Reset with every input nonzero.
        reset         = 1'b1;
        Hold          = 1'b1;
        Flush_EX      = 1'b1;
        MEM_Read_Data = 32'hAAAA_AAAA;
        drive_ex(5'd5, 1'b1, 1'b1, 32'hFFFF_FFFF, 5'd5, 5'd3);
        @(posedge clk);
        #1;
        exp_exm("reset", 5'd0, 1'b0, 1'b0, 32'h0);
        exp_mwb("reset", 5'd0, 1'b0, 32'h0);
        push("reset.count", 8, 32'h0);
        step();
        check_stall("reset.stall_comb", 1'b1);

        reset         = 1'b0;
        Hold          = 1'b0;
        Flush_EX      = 1'b0;
        MEM_Read_Data = '0;
        drive_ex(5'd0, 1'b0, 1'b0, 32'h0, 5'd0, 5'd0);
        push("idle.count", 8, 32'h0);
        step();

        // 2. ALU write-back to r8.
        drive_ex(5'd8, 1'b1, 1'b0, 32'h1234, 5'd8, 5'd2);
        check_stall("alu.no_stall", 1'b0);
        exp_exm("alu", 5'd8, 1'b1, 1'b0, 32'h1234);
        step();

        // 3. Load to r9 consumed by rt in ID.
        drive_ex(5'd9, 1'b1, 1'b1, 32'h0100, 5'd1, 5'd9);
        check_stall("load.stall", 1'b1);
        exp_exm("load", 5'd9, 1'b1, 1'b1, 32'h0100);
        exp_mwb("alu_wb", 5'd8, 1'b1, 32'h1234);
        push("load.count", 8, 32'd1);
        step();

        drive_ex(5'd9, 1'b1, 1'b1, 32'h0100, 5'd10, 5'd10);
        check_stall("load.no_match", 1'b0);

        // 4. Load to $zero: no stall, write enable stripped.
        MEM_Read_Data = 32'hCAFE_F00D;
        drive_ex(5'd0, 1'b1, 1'b1, 32'h0055, 5'd0, 5'd10);
        check_stall("zero.no_stall", 1'b0);
        exp_exm("zero", 5'd0, 1'b0, 1'b1, 32'h0055);
        exp_mwb("load_wb", 5'd9, 1'b1, 32'hCAFE_F00D);
        push("zero.count", 8, 32'd1);
        step();

        MEM_Read_Data = 32'h0000_7777;
        drive_ex(5'd3, 1'b1, 1'b0, 32'h0333, 5'd0, 5'd0);
        exp_exm("r3", 5'd3, 1'b1, 1'b0, 32'h0333);
        exp_mwb("zero_wb", 5'd0, 1'b0, 32'h0000_7777);
        step();

        // 5. Fill both slices, then hold+flush together, then flush alone.
        drive_ex(5'd4, 1'b1, 1'b0, 32'h0444, 5'd0, 5'd0);
        exp_exm("r4", 5'd4, 1'b1, 1'b0, 32'h0444);
        exp_mwb("r3_wb", 5'd3, 1'b1, 32'h0333);
        step();

        Hold     = 1'b1;
        Flush_EX = 1'b1;
        drive_ex(5'd6, 1'b1, 1'b1, 32'h0666, 5'd6, 5'd0);
        check_stall("hold.stall", 1'b1);
        for (int i = 0; i < 3; i++) begin
            exp_exm("hold", 5'd4, 1'b1, 1'b0, 32'h0444);
            exp_mwb("hold", 5'd3, 1'b1, 32'h0333);
            push("hold.count", 8, 32'(2 + i));
            step();
        end

        Hold = 1'b0;
        drive_ex(5'd6, 1'b1, 1'b1, 32'h0666, 5'd0, 5'd0);
        exp_exm("flush", 5'd0, 1'b0, 1'b0, 32'h0);
        exp_mwb("flush", 5'd4, 1'b1, 32'h0444);
        push("flush.count", 8, 32'd4);
        step();

        // 6. Continuous load-use stall drives the counter to saturation.
        Flush_EX      = 1'b0;
        MEM_Read_Data = 32'h0000_BEEF;
        drive_ex(5'd7, 1'b1, 1'b1, 32'h0070, 5'd7, 5'd0);
        check_stall("sat.stall", 1'b1);
        for (int i = 1; i <= 20; i++) begin
            push("sat.count", 8, (4 + i > 15) ? 32'd15 : 32'(4 + i));
            push("sat.ex_mem_rd", 0, 32'd7);
            if (i >= 2) push("sat.mem_wb_data", 6, 32'h0000_BEEF);
            step();
        end

        reset = 1'b1;
        exp_exm("midreset", 5'd0, 1'b0, 1'b0, 32'h0);
        exp_mwb("midreset", 5'd0, 1'b0, 32'h0);
        push("midreset.count", 8, 32'h0);
        step();

        reset = 1'b0;
        exp_exm("restart", 5'd7, 1'b1, 1'b1, 32'h0070);
        push("restart.count", 8, 32'd1);
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
